// File: rtl/gr_file_sweep.sv
// -----------------------------------------------------------------------------
// gr_file_sweep
//   32-entry general register file for the execute stage. One write port and
//   two combinational read ports. R0 reads as constant zero. After Clr the
//   sweep sequencer zeroes R1..R31 one entry per clock. Writes are held off
//   until the sweep finishes. A same-cycle bypass forwards write-back data
//   to both read ports.
//
// Ports
//   Clk    in   1       clock, rising edge
//   Clr    in   1       synchronous active-high reset; restarts the sweep
//   WE     in   1       write enable from write-back
//   RW     in   ADDR_W  write address
//   PW     in   DATA_W  write data
//   RA     in   ADDR_W  read port A address
//   RB     in   ADDR_W  read port B address
//   PA     out  DATA_W  read port A data (combinational)
//   PB     out  DATA_W  read port B data (combinational)
//   Ready  out  1       sweep complete, writes accepted
//   WDrop  out  1       registered pulse: write discarded during the sweep
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// gr_ld_reg
//   Load-enabled storage register with no reset. Contents survive Clr; the
//   sweep sequencer is what zeroes them.
//
// Ports
//   Clk   in   1       clock
//   i_ld  in   1       load enable
//   i_d   in   DATA_W  load data
//   o_q   out  DATA_W  stored value
// -----------------------------------------------------------------------------
module gr_ld_reg #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge Clk) begin
        if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// -----------------------------------------------------------------------------
// Sweep / write-control FSM
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_SWEEP | clearing reg[cnt] each edge; reads return 0; writes dropped
//   ST_READY | normal operation; writes accepted; bypass active
// -----------------------------------------------------------------------------
module gr_file_sweep #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              WE,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] PW,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic              Ready,
    output logic              WDrop
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                r_wdrop;
    logic                w_wdrop_nxt;

    // Single shared load port into storage: either a sweep clear or a write.
    logic                w_ld_en;
    logic [ADDR_W-1:0]   w_ld_addr;
    logic [DATA_W-1:0]   w_ld_data;

    logic                w_wr_req;
    logic [DATA_W-1:0]   w_q [NUM_REGS];

    // A write to R0 is a no-op everywhere, including WDrop.
    assign w_wr_req = WE && (RW != '0);

    // -------------------------------------------------------------------------
    // State register. Clr dominates everything, including the sweep itself.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= ST_SWEEP;
            r_cnt   <= LP_ONE;
            r_wdrop <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wdrop <= w_wdrop_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, sweep counter and storage load selection.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wdrop_nxt = 1'b0;
        w_ld_en     = 1'b0;
        w_ld_addr   = RW;
        w_ld_data   = PW;

        if (!Clr) begin
            unique case (r_state)
                ST_SWEEP: begin
                    w_ld_en   = 1'b1;
                    w_ld_addr = r_cnt;
                    w_ld_data = '0;
                    // The counter reloads to 1 rather than wrapping so it
                    // never points at R0.
                    if (r_cnt == LP_LAST) begin
                        w_state_nxt = ST_READY;
                        w_cnt_nxt   = LP_ONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + LP_ONE;
                    end
                    w_wdrop_nxt = w_wr_req;
                end
                ST_READY: begin
                    w_ld_en   = w_wr_req;
                    w_ld_addr = RW;
                    w_ld_data = PW;
                end
                default: begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = LP_ONE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage: R0 is constant zero, R1..R(NUM_REGS-1) are load registers.
    // -------------------------------------------------------------------------
    assign w_q[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        logic w_ld;

        assign w_ld = w_ld_en && (w_ld_addr == ADDR_W'(g));

        gr_ld_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .Clk  (Clk),
            .i_ld (w_ld),
            .i_d  (w_ld_data),
            .o_q  (w_q[g])
        );
    end

    // -------------------------------------------------------------------------
    // Read ports. During the sweep every entry reads as already cleared, so
    // stale contents from before Clr are never exposed.
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] rd_port(
        input logic [ADDR_W-1:0] i_addr,
        input state_t            i_state,
        input logic              i_we,
        input logic [ADDR_W-1:0] i_rw,
        input logic [DATA_W-1:0] i_pw,
        input logic [DATA_W-1:0] i_q
    );
        logic [DATA_W-1:0] v;
        v = i_q;
        if (i_addr == '0) begin
            v = '0;
        end else if (i_state == ST_SWEEP) begin
            v = '0;
        end else if (i_we && (i_addr == i_rw)) begin
            v = i_pw;
        end
        return v;
    endfunction

    always_comb begin
        PA = rd_port(RA, r_state, WE, RW, PW, w_q[RA]);
        PB = rd_port(RB, r_state, WE, RW, PW, w_q[RB]);
    end

    assign Ready = (r_state == ST_READY);
    assign WDrop = r_wdrop;

endmodule

// File: doc/gr_file_sweep.md
Name: gr_file_sweep

Overview:
- 32-entry general register file built from the 32-bit load-enabled storage registers: one write port and two read ports (operands A and B) feeding the execute stage.
- R0 is hardwired to zero.
- A synchronous clear sequencer zeroes R1..R31 one register per cycle after reset and holds off writes until done.
- Same-cycle write-to-read bypass, so the decode stage sees write-back data without an extra cycle.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers (2**ADDR_W); entry 0 is constant zero

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Clr  input  1  synchronous active-high reset; restarts clear sweep
- WE  input  1  write enable from write-back stage
- RW  input  ADDR_W  write register address
- PW  input  DATA_W  write data
- RA  input  ADDR_W  read port A address
- RB  input  ADDR_W  read port B address
- PA  output  DATA_W  read port A data (combinational)
- PB  output  DATA_W  read port B data (combinational)
- Ready  output  1  high when sweep complete and writes are accepted
- WDrop  output  1  registered one-cycle pulse: a write was discarded because Ready was low

Behaviour:
- One clock (Clk); reset Clr is synchronous, active-high. No asynchronous paths.
- States: SWEEP, READY. Sweep counter cnt, ADDR_W bits.
- Clr=1 at an edge:
  - state<=SWEEP, cnt<=1, WDrop<=0.
  - Register contents are not touched by Clr itself.
  - Clr dominates WE and the sweep.
- SWEEP, Clr=0 at an edge:
  - reg[cnt]<=0, cnt<=cnt+1.
  - If cnt==NUM_REGS-1: state<=READY, cnt<=1.
  - So Ready rises after exactly NUM_REGS-1 (31) edges with Clr low after Clr deasserts.
- Ready = (state==READY); low from the first edge with Clr=1 onward.
- Writes:
  - In READY, WE=1 and RW!=0: reg[RW]<=PW at the edge.
  - WE=1 with RW==0: ignored, no WDrop.
  - WE=1 with RW!=0 while state==SWEEP and Clr=0: write discarded, WDrop<=1 for the next cycle.
  - Otherwise WDrop<=0.
  - WE during Clr=1 is discarded without WDrop.
- Reads, combinational, per port X∈{A,B}:
  - If RX==0: 0.
  - Else if state==SWEEP: 0. Sweep in progress, contents treated as cleared.
  - Else if WE && RX==RW: PW (bypass).
  - Else: reg[RX].
  - Both ports may read the same address; both bypass simultaneously.
- Clr mid-sweep: sweep restarts at R1; partially cleared entries are re-cleared.
- Clr while READY: contents retained internally but unreadable (0) until the new sweep rewrites them to 0.
- Latency:
  - Write visible on PA/PB the same cycle via bypass, and from storage after the edge.
  - Read address to data is 0 cycles.
- Widths: no arithmetic on data. cnt wraps only via explicit reload to 1, never to 0.
- Reset values: Ready=0, WDrop=0. PA=PB=0 for the entire sweep.

Test Plan:
- Clr high 2 cycles, then low; count edges -> Ready rises after exactly 31 edges; PA=PB=0 for RA=RB=5 throughout; after Ready, RA=31 reads 0x00000000.
- After Ready: WE=1 RW=7 PW=0xDEADBEEF, RA=7 same cycle -> PA=0xDEADBEEF (bypass); next cycle WE=0, RA=RB=7 -> PA=PB=0xDEADBEEF.
- After Ready: WE=1 RW=0 PW=0xFFFFFFFF -> WDrop stays 0; RA=0 reads 0 before and after the edge.
- During sweep (10 edges after Clr release): WE=1 RW=3 PW=0x12345678 -> WDrop=1 for exactly the next cycle; after Ready, RA=3 reads 0.
- After Ready write R9=0xA5A5A5A5; assert Clr 1 cycle at sweep edge 15 of a second reset -> Ready stays low a full 31 edges from that release; RA=9 reads 0 throughout and after Ready.
- Random write/read traffic after Ready against a reference model, including RA==RB==RW collisions -> PA/PB match model every cycle; WDrop never asserts.
